spart: RTL and testbench

- Special-purpose asynchronous receiver/transmitter (SPART): 8N1 serial transmitter and receiver with a programmable baud-rate generator.
- Attaches to a processor through an 8-bit bidirectional bus: chip select, read/write strobe and 2-bit register address.
- Sits between the processor-side bus driver and the board serial pins (txd/rxd).

---
 rtl/spart_pkg.sv | 27 ++
 rtl/spart_baud_gen.sv | 40 ++++
 rtl/spart.sv | 230 +++++++++++++++++++++++
 tb/tb_spart.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared constants and state types for the SPART serial port.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Divisor buffer plus 16-bit down-counter; emits one tick every DB+1 clocks.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET = 16'h028A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [7:0]  i_wdata,
    output logic [15:0] o_db,
    output logic        o_tick
);

    logic [15:0] r_db;
    logic [15:0] r_cnt;
    logic        r_reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db     <= DB_RESET;
            r_cnt    <= DB_RESET;
            r_reload <= 1'b0;
        end else begin
            r_reload <= i_wr_lo | i_wr_hi;
            if (i_wr_lo) r_db[7:0]  <= i_wdata;
            if (i_wr_hi) r_db[15:8] <= i_wdata;
            // A pending reload takes the freshly written divisor, not the stale count
            if (r_reload || (r_cnt == 16'd0))
                r_cnt <= r_db;
            else
                r_cnt <= r_cnt - 16'd1;
        end
    end

    assign o_tick = (r_cnt == 16'd0) && !r_reload;
    assign o_db   = r_db;

endmodule

// File: rtl/spart.sv
// SPART top: processor bus interface plus independent 8N1 transmitter and receiver.
// state    | meaning
// TX_IDLE  | line high, waits for a loaded buffer and a tick
// TX_START | start bit (0) for 16 ticks
// TX_DATA  | 8 data bits, LSB first, 16 ticks each
// TX_STOP  | stop bit (1) for 16 ticks, then tbr=1
// RX_IDLE  | waits for a sampled 0 on a tick
// RX_START | counts to mid start bit, rejects glitches
// RX_DATA  | samples 8 bits every 16 ticks
// RX_STOP  | samples stop bit; 1 stores the byte, 0 discards it
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET = 16'h028A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        w_wr;
    logic        w_rd;
    logic        w_wr_buf;
    logic        w_wr_dbl;
    logic        w_wr_dbh;
    logic        w_rd_buf;
    logic        w_tick;
    logic [15:0] w_db;
    logic [7:0]  w_rdata;
    logic [7:0]  w_wdata;

    tx_state_t   r_tx_state;
    logic [3:0]  r_tx_tcnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_buf;
    logic [7:0]  r_tx_shift;
    logic        r_txd;
    logic        r_tbr;

    rx_state_t   r_rx_state;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic [3:0]  r_rx_tcnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_buf;
    logic        r_rda;

    assign w_wr     = iocs && !iorw;
    assign w_rd     = iocs && iorw;
    assign w_wr_buf = w_wr && (ioaddr == ADDR_BUF);
    assign w_wr_dbl = w_wr && (ioaddr == ADDR_DBL);
    assign w_wr_dbh = w_wr && (ioaddr == ADDR_DBH);
    assign w_rd_buf = w_rd && (ioaddr == ADDR_BUF);
    assign w_wdata  = databus;

    always_comb begin
        w_rdata = 8'h00;
        case (ioaddr)
            ADDR_BUF:  w_rdata = r_rx_buf;
            ADDR_STAT: w_rdata = {6'b000000, r_tbr, r_rda};
            ADDR_DBL:  w_rdata = w_db[7:0];
            default:   w_rdata = w_db[15:8];
        endcase
    end

    assign databus = w_rd ? w_rdata : 8'hzz;

    spart_baud_gen #(
        .DB_RESET (DB_RESET)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_wr_lo (w_wr_dbl),
        .i_wr_hi (w_wr_dbh),
        .i_wdata (w_wdata),
        .o_db    (w_db),
        .o_tick  (w_tick)
    );

    // Transmitter; tbr gates buffer loads so a held strobe sends one byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_tcnt  <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_buf   <= 8'h00;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
            r_tbr      <= 1'b1;
        end else begin
            if (w_wr_buf && r_tbr) begin
                r_tx_buf <= w_wdata;
                r_tbr    <= 1'b0;
            end
            case (r_tx_state)
                TX_IDLE: begin
                    if (!r_tbr && w_tick) begin
                        r_tx_state <= TX_START;
                        r_tx_tcnt  <= 4'd0;
                        r_tx_shift <= r_tx_buf;
                        r_txd      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TICK_LAST) begin
                            r_tx_state <= TX_DATA;
                            r_tx_tcnt  <= 4'd0;
                            r_tx_bit   <= 3'd0;
                            r_txd      <= r_tx_shift[0];
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TICK_LAST) begin
                            r_tx_tcnt  <= 4'd0;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            if (r_tx_bit == 3'd7) begin
                                r_tx_state <= TX_STOP;
                                r_txd      <= 1'b1;
                            end else begin
                                r_tx_bit <= r_tx_bit + 3'd1;
                                r_txd    <= r_tx_shift[1];
                            end
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TICK_LAST) begin
                            r_tx_state <= TX_IDLE;
                            r_tx_tcnt  <= 4'd0;
                            r_tbr      <= 1'b1;
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_txd      <= 1'b1;
                end
            endcase
        end
    end

    // Receiver; a completing byte sets rda after the read-clear so set wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_tcnt  <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_buf   <= 8'h00;
            r_rda      <= 1'b0;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            if (w_rd_buf) r_rda <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_tick && !r_rx_s2) begin
                        r_rx_state <= RX_START;
                        r_rx_tcnt  <= 4'd0;
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == TICK_HALF) begin
                            r_rx_tcnt <= 4'd0;
                            r_rx_bit  <= 3'd0;
                            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == TICK_LAST) begin
                            r_rx_tcnt  <= 4'd0;
                            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                            if (r_rx_bit == 3'd7)
                                r_rx_state <= RX_STOP;
                            else
                                r_rx_bit <= r_rx_bit + 3'd1;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == TICK_LAST) begin
                            r_rx_state <= RX_IDLE;
                            r_rx_tcnt  <= 4'd0;
                            if (r_rx_s2) begin
                                r_rx_buf <= r_rx_shift;
                                r_rda    <= 1'b1;
                            end
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign txd = r_txd;
    assign tbr = r_tbr;
    assign rda = r_rda;

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart: bus access, TX waveform, RX framing, loopback and reset.
module tb_spart;
    import spart_pkg::*;

    logic       clk;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    wire        rxd;

    logic [7:0] r_drv;
    logic       r_drv_en;
    logic       r_loop;
    logic       r_rxd;

    int n_tests;
    int n_fail;

    logic r_cap     [0:339];
    logic r_cap_tbr [0:339];

    assign databus = r_drv_en ? r_drv : 8'hzz;
    assign rxd     = r_loop ? txd : r_rxd;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference line level at sample i (32 clocks per bit with DB=1) for an 8N1 frame of b
    function automatic logic exp_line(input logic [7:0] b, input int i);
        int slot;
        slot = i / 32;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot - 1];
        return 1'b1;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; r_drv = d; r_drv_en = 1'b1;
        @(posedge clk);
        #1;
        iocs = 1'b0; iorw = 1'b1; r_drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1;
        d = databus;
        @(posedge clk);
        #1;
        iocs = 1'b0;
    endtask

    task automatic capture_tx(output logic found);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (txd === 1'b0) found = 1'b1;
        end
        if (found) begin
            r_cap[0] = txd;
            r_cap_tbr[0] = tbr;
            for (int i = 1; i < 340; i++) begin
                @(negedge clk);
                r_cap[i] = txd;
                r_cap_tbr[i] = tbr;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        r_rxd = 1'b0;
        repeat (32) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            r_rxd = b[k];
            repeat (32) @(negedge clk);
        end
        r_rxd = stop_bit;
        repeat (stop_bit ? 32 : 28) @(negedge clk);
        r_rxd = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iocs = 1'b0; iorw = 1'b1; ioaddr = ADDR_BUF;
        r_drv = 8'h00; r_drv_en = 1'b0; r_loop = 1'b0; r_rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        n_tests++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got=%b exp=1", txd); end
        n_tests++;
        if (tbr !== 1'b1) begin n_fail++; $display("FAIL reset_tbr got=%b exp=1", tbr); end
        n_tests++;
        if (rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda got=%b exp=0", rda); end
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL reset_status got=%h exp=02", d); end
        bus_read(ADDR_DBL, d);
        n_tests++;
        if (d !== 8'h8A) begin n_fail++; $display("FAIL reset_dbl got=%h exp=8a", d); end
        bus_read(ADDR_DBH, d);
        n_tests++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL reset_dbh got=%h exp=02", d); end
    endtask

    task automatic test_baud();
        logic [7:0] d;
        int ticks;
        bus_write(ADDR_DBL, 8'h00);
        bus_write(ADDR_DBH, 8'h00);
        repeat (4) @(negedge clk);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.u_baud.o_tick === 1'b1) ticks++;
        end
        n_tests++;
        if (ticks != 20) begin n_fail++; $display("FAIL baud_db0 ticks=%0d exp=20", ticks); end
        bus_write(ADDR_DBL, 8'h01);
        repeat (4) @(negedge clk);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.u_baud.o_tick === 1'b1) ticks++;
        end
        n_tests++;
        if (ticks != 20) begin n_fail++; $display("FAIL baud_db1 ticks=%0d exp=20", ticks); end
        bus_read(ADDR_DBL, d);
        n_tests++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL db_lo got=%h exp=01", d); end
        bus_read(ADDR_DBH, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL db_hi got=%h exp=00", d); end
    endtask

    task automatic test_tx_directed();
        logic found;
        int bad;
        int zeros;
        fork
            capture_tx(found);
            begin
                @(negedge clk);
                iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_BUF; r_drv = 8'h6D; r_drv_en = 1'b1;
                @(posedge clk);
                #1;
                n_tests++;
                if (tbr !== 1'b0) begin n_fail++; $display("FAIL tx_tbr_drop got=%b exp=0", tbr); end
                r_drv = 8'h92;
                @(posedge clk);
                #1;
                iocs = 1'b0; iorw = 1'b1; r_drv_en = 1'b0;
            end
        join
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL tx_start_timeout got=no_start exp=start_bit");
        end else begin
            bad = -1;
            for (int i = 0; i < 340; i++)
                if (bad < 0 && r_cap[i] !== exp_line(8'h6D, i)) bad = i;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL tx_wave_6d at sample %0d got=%b exp=%b", bad, r_cap[bad], exp_line(8'h6D, bad));
            end
            n_tests++;
            if (r_cap_tbr[319] !== 1'b0 || r_cap_tbr[320] !== 1'b1) begin
                n_fail++;
                $display("FAIL tx_tbr_return got=%b%b exp=01", r_cap_tbr[319], r_cap_tbr[320]);
            end
        end
        zeros = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        n_tests++;
        if (zeros != 0) begin n_fail++; $display("FAIL tx_single_frame low_cycles=%0d exp=0", zeros); end
    endtask

    task automatic test_tx_random();
        logic       found;
        logic [7:0] b;
        int         bad;
        for (int f = 0; f < 3; f++) begin
            b = 8'($urandom);
            fork
                capture_tx(found);
                bus_write(ADDR_BUF, b);
            join
            bad = (found) ? -1 : 0;
            if (found)
                for (int i = 0; i < 340; i++)
                    if (bad < 0 && r_cap[i] !== exp_line(b, i)) bad = i;
            n_tests++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL tx_wave_rand byte=%h sample=%0d found=%b got=%b exp=%b", b, bad, found, r_cap[bad], exp_line(b, bad));
            end
        end
    endtask

    task automatic test_loopback();
        logic       found;
        logic [7:0] b;
        logic [7:0] d;
        r_loop = 1'b1;
        for (int f = 0; f < 3; f++) begin
            b = (f == 0) ? 8'hA5 : 8'($urandom);
            fork
                capture_tx(found);
                bus_write(ADDR_BUF, b);
            join
            n_tests++;
            if (rda !== 1'b1 || !found) begin
                n_fail++; $display("FAIL loop_rda byte=%h got=%b found=%b exp=1", b, rda, found);
            end
            bus_read(ADDR_BUF, d);
            n_tests++;
            if (d !== b) begin n_fail++; $display("FAIL loop_data got=%h exp=%h", d, b); end
            n_tests++;
            if (rda !== 1'b0) begin n_fail++; $display("FAIL loop_rda_clear got=%b exp=0", rda); end
        end
        r_loop = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_rx_glitch();
        logic [7:0] d;
        @(negedge clk);
        r_rxd = 1'b0;
        repeat (8) @(negedge clk);
        r_rxd = 1'b1;
        repeat (500) @(negedge clk);
        n_tests++;
        if (rda !== 1'b0) begin n_fail++; $display("FAIL rx_glitch_rda got=%b exp=0", rda); end
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL rx_glitch_status got=%h exp=02", d); end
    endtask

    task automatic test_rx_framing_overrun();
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] d;
        b1 = 8'($urandom);
        b2 = ~b1 ^ 8'($urandom_range(1, 255));
        send_frame(8'($urandom), 1'b0);
        repeat (200) @(negedge clk);
        n_tests++;
        if (rda !== 1'b0) begin n_fail++; $display("FAIL rx_framing_rda got=%b exp=0", rda); end
        send_frame(b1, 1'b1);
        n_tests++;
        if (rda !== 1'b1) begin n_fail++; $display("FAIL rx_first_rda got=%b exp=1", rda); end
        send_frame(b2, 1'b1);
        bus_read(ADDR_STAT, d);
        n_tests++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL rx_overrun_status got=%h exp=03", d); end
        bus_read(ADDR_BUF, d);
        n_tests++;
        if (d !== b2) begin n_fail++; $display("FAIL rx_overrun_data got=%h exp=%h", d, b2); end
        n_tests++;
        if (rda !== 1'b0) begin n_fail++; $display("FAIL rx_overrun_clear got=%b exp=0", rda); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        bus_write(ADDR_BUF, 8'h00);
        repeat (100) @(negedge clk);
        n_tests++;
        if (txd !== 1'b0 || tbr !== 1'b0) begin
            n_fail++; $display("FAIL midframe_busy txd=%b tbr=%b exp=0,0", txd, tbr);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (txd !== 1'b1 || tbr !== 1'b1 || rda !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset txd=%b tbr=%b rda=%b exp=1,1,0", txd, tbr, rda);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_read(ADDR_DBL, d);
        n_tests++;
        if (d !== 8'h8A) begin n_fail++; $display("FAIL midframe_db got=%h exp=8a", d); end
        repeat (200) @(negedge clk);
        n_tests++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL midframe_idle txd=%b exp=1", txd); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_baud();
        test_tx_directed();
        test_tx_random();
        test_loopback();
        test_rx_glitch();
        test_rx_framing_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
